ws2812_receiver: RTL and testbench
==================================

Name: ws2812_receiver

Overview:
- Decodes a WS2812-style single-wire pulse-width stream (20 MHz clock domain, 25-cycle bit period) back into 24-bit pixel words, and detects the frame-terminating reset gap.
- Acts as the receive end of the LED line protocol. Used for loopback self-test of the LED transmit path and for daisy-chain monitoring on the FPGA.
- A bit's value is decided from the measured high-pulse width. Frames are delimited by a sustained low period.

Parameters:
- THRESH, 12, high-pulse length in cycles at or above which a bit decodes as 1 (nominal 0 = 8 cycles, 1 = 16 cycles)
- MIN_HIGH, 4, high pulses shorter than this are glitches
- MAX_HIGH, 22, high pulses longer than this are protocol errors
- RES_CYCLES, 1000, continuous low cycles that signal end of frame (50 us)
- MAX_LEDS, 60, pixels accepted per frame
- IDX_W, 6, width of pixel index, ceil(log2(MAX_LEDS))

Ports:
- clk  in  1  system clock, 20 MHz
- reset  in  1  asynchronous, active-low reset
- din  in  1  asynchronous serial LED line
- pixel  out  24  last decoded pixel, MSB = first bit received
- pixel_valid  out  1  one-cycle strobe; pixel and pixel_index are valid
- pixel_index  out  IDX_W  position of pixel within the current frame, 0-based
- frame_done  out  1  one-cycle strobe when the reset gap completes after at least one bit
- frame_len  out  IDX_W+1  pixels delivered in the frame just finished; valid with frame_done and held until the next frame_done
- err  out  1  one-cycle strobe on a glitch, over-long high, or partial pixel at frame end
- overflow  out  1  sticky: frame carried more than MAX_LEDS pixels; cleared on frame_done
- busy  out  1  high while inside a frame (first rising edge through frame_done)

Behaviour:
- Reset asserted (low): all outputs 0 and state SYNC, from any state, mid-frame included. The partial pixel is discarded and no strobes are issued.
- din passes through a 2-flop synchronizer. All edges and timing below refer to the synchronized signal ds, which lags din by 2 cycles.
- One counter, cnt (11 bits, saturating), measures the current high or low run. A 5-bit bit counter and a 24-bit shift register hold the partial pixel.
- States:
  - SYNC: accept nothing until ds has been low for RES_CYCLES, then go to IDLE. This prevents decoding into a frame already in progress.
  - IDLE: on ds rising edge, go to HIGH with cnt=1 and set busy=1.
  - HIGH: cnt increments each cycle.
    - On falling edge with MIN_HIGH <= cnt <= MAX_HIGH: shift in bit (cnt >= THRESH), then go to LOW with cnt=1.
    - On falling edge with cnt < MIN_HIGH: err strobe, bit dropped, go to LOW.
    - If cnt would exceed MAX_HIGH: err strobe, discard partial pixel, go to SYNC.
  - LOW: cnt increments.
    - Rising edge before RES_CYCLES: go to HIGH with cnt=1. Inter-bit low length is not otherwise checked.
    - cnt reaching RES_CYCLES: end of frame; go to IDLE.
- Pixel completion: on the 24th accepted bit, pixel is updated and pixel_valid pulses for 1 cycle on the cycle after the falling edge of ds (3 cycles after the din edge).
  - pixel_index = the pixel count before increment.
  - The pixel count saturates at MAX_LEDS.
  - Pixels beyond MAX_LEDS: no pixel_valid; overflow is set.
- End of frame (LOW reaching RES_CYCLES):
  - frame_done pulses for 1 cycle and frame_len = pixel count.
  - If the bit counter is nonzero, err pulses in the same cycle and the partial pixel is discarded.
  - Pixel count, bit counter and overflow are cleared; busy drops.
- err and pixel_valid never coincide.
- Widths: frame_len is IDX_W+1 bits so that the value MAX_LEDS is representable. cnt saturates at 2047.

Decomposition:
- Shared package (shared with the LED transmit path): the 20 MHz bit timing constants (T0H=8, T1H=16, period=25), THRESH, and RES_CYCLES, plus the state enumeration.
- One natural sub-module: sync_edge, the 2-flop synchronizer with rise/fall pulse outputs. It is reusable for other asynchronous inputs.

Test Plan:
- Bit pattern 0xFF0000 at nominal timing (16H/9L for 1s, 8H/17L for 0s), then 1000 low -> pixel=0xFF0000, pixel_valid with index 0, then frame_done with frame_len=1, err=0.
- 3 pixels 0x123456, 0xABCDEF, 0x000001 back to back -> 3 strobes with index 0, 1, 2 in order; frame_len=3.
- Reset released while din toggles mid-frame -> no pixel_valid until 1000 low cycles, then a clean frame decodes correctly.
- High pulses of 11 and 12 cycles -> decode 0 and 1 respectively; a 3-cycle glitch -> err, bit dropped; a 30-cycle high -> err, return to SYNC.
- Frame of 61 pixels -> 60 pixel_valid strobes, overflow=1, frame_len=60, overflow cleared after frame_done.
- 10 bits then 1000 low -> err and frame_done in the same cycle, frame_len=0, no pixel_valid; next frame decodes cleanly.

Source files
------------

// File: rtl/ws2812_receiver_pkg.sv
// Shared WS2812 line timing at 20 MHz (50 ns per cycle) and the receiver state encoding.
package ws2812_receiver_pkg;

   localparam int T0H        = 8;
   localparam int T1H        = 16;
   localparam int T_BIT      = 25;
   localparam int BIT_THRESH = (T0H + T1H) / 2;
   localparam int RES_LOW    = 1000;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } rx_state_t;

endpackage

// File: rtl/ws2812_receiver_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle rise/fall pulses.
module ws2812_receiver_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign q    = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 line receiver: pulse-width bit decode, 24-bit pixel assembly, reset-gap framing.
//
// state   | meaning
// SYNC    | waiting for RES_CYCLES of continuous low before trusting the line
// IDLE    | between frames, waiting for the first rising edge
// HIGH    | measuring a high pulse
// LOW     | measuring the low gap after a bit; long enough gap ends the frame
module ws2812_receiver
   import ws2812_receiver_pkg::*;
#(
   parameter int THRESH     = BIT_THRESH,
   parameter int MIN_HIGH   = T0H / 2,
   parameter int MAX_HIGH   = T_BIT - 3,
   parameter int RES_CYCLES = RES_LOW,
   parameter int MAX_LEDS   = 60,
   parameter int IDX_W      = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               din,
   output logic [23:0]        pixel,
   output logic               pixel_valid,
   output logic [IDX_W-1:0]   pixel_index,
   output logic               frame_done,
   output logic [IDX_W:0]     frame_len,
   output logic               err,
   output logic               overflow,
   output logic               busy
);

   localparam logic [10:0]    C_THRESH = 11'(THRESH);
   localparam logic [10:0]    C_MIN    = 11'(MIN_HIGH);
   localparam logic [10:0]    C_MAX    = 11'(MAX_HIGH);
   localparam logic [10:0]    C_RES    = 11'(RES_CYCLES);
   localparam logic [IDX_W:0] C_LEDS   = (IDX_W+1)'(MAX_LEDS);

   logic ds, rise, fall;

   ws2812_receiver_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (ds),
      .rise  (rise),
      .fall  (fall)
   );

   rx_state_t     state, state_n;
   logic [10:0]   cnt, cnt_n, cnt_inc;
   logic [4:0]    bit_cnt;
   logic [23:0]   sr, sr_shift;
   logic [IDX_W:0] pix_cnt;
   logic          accept, start, eof, abort, glitch, bit_val;

   assign cnt_inc  = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
   assign bit_val  = (cnt >= C_THRESH);
   assign sr_shift = {sr[22:0], bit_val};

   always_comb begin
      state_n = state;
      cnt_n   = cnt_inc;
      accept  = 1'b0;
      start   = 1'b0;
      eof     = 1'b0;
      abort   = 1'b0;
      glitch  = 1'b0;
      case (state)
         ST_SYNC: begin
            if (ds) begin
               cnt_n = 11'd0;
            end else if (cnt_inc >= C_RES) begin
               state_n = ST_IDLE;
               cnt_n   = 11'd0;
            end
         end
         ST_IDLE: begin
            cnt_n = 11'd0;
            if (rise) begin
               state_n = ST_HIGH;
               cnt_n   = 11'd1;
               start   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_n = ST_LOW;
               cnt_n   = 11'd1;
               if (cnt < C_MIN) glitch = 1'b1;
               else             accept = 1'b1;
            end else if (cnt >= C_MAX) begin
               // The pulse is about to run past MAX_HIGH: the line is not a valid stream.
               state_n = ST_SYNC;
               cnt_n   = 11'd0;
               abort   = 1'b1;
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_n = ST_HIGH;
               cnt_n   = 11'd1;
            end else if (cnt_inc >= C_RES) begin
               state_n = ST_IDLE;
               cnt_n   = 11'd0;
               eof     = 1'b1;
            end
         end
         default: begin
            state_n = ST_SYNC;
            cnt_n   = 11'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_SYNC;
         cnt   <= 11'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt     <= 5'd0;
         sr          <= 24'd0;
         pix_cnt     <= '0;
         pixel       <= 24'd0;
         pixel_valid <= 1'b0;
         pixel_index <= '0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         err         <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         err         <= glitch | abort;
         if (start) busy <= 1'b1;
         if (accept) begin
            sr <= sr_shift;
            if (bit_cnt == 5'd23) begin
               bit_cnt <= 5'd0;
               if (pix_cnt < C_LEDS) begin
                  pixel       <= sr_shift;
                  pixel_valid <= 1'b1;
                  pixel_index <= pix_cnt[IDX_W-1:0];
                  pix_cnt     <= pix_cnt + 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end
         if (eof) begin
            frame_done <= 1'b1;
            frame_len  <= pix_cnt;
            err        <= (bit_cnt != 5'd0);
         end
         if (eof || abort) begin
            bit_cnt  <= 5'd0;
            sr       <= 24'd0;
            pix_cnt  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_receiver.sv
// Directed bench for ws2812_receiver: nominal frames, threshold/glitch edges, resync, overflow, partial pixel.
module tb_ws2812_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        din = 1'b0;
   logic [23:0] pixel;
   logic        pixel_valid;
   logic [5:0]  pixel_index;
   logic        frame_done;
   logic [6:0]  frame_len;
   logic        err;
   logic        overflow;
   logic        busy;

   ws2812_receiver dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .pixel_index (pixel_index),
      .frame_done  (frame_done),
      .frame_len   (frame_len),
      .err         (err),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #25 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int          pv_cnt = 0, fd_cnt = 0, err_cnt = 0, err_fd_cnt = 0, coinc_cnt = 0;
   int          last_flen = -1;
   logic [23:0] pix_log [0:127];
   int          idx_log [0:127];

   always @(posedge clk) begin
      #1;
      if (reset) begin
         if (pixel_valid) begin
            if (pv_cnt < 128) begin
               pix_log[pv_cnt] = pixel;
               idx_log[pv_cnt] = int'(pixel_index);
            end
            pv_cnt++;
         end
         if (frame_done) begin
            fd_cnt++;
            last_flen = int'(frame_len);
         end
         if (err) err_cnt++;
         if (err && frame_done) err_fd_cnt++;
         if (err && pixel_valid) coinc_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      din = 1'b1;
      cyc(h);
      din = 1'b0;
      cyc(l);
   endtask

   task automatic send_bit(input logic b);
      if (b) pulse(16, 9);
      else   pulse(8, 17);
   endtask

   task automatic send_pixel(input logic [23:0] p);
      for (int i = 23; i >= 0; i--) send_bit(p[i]);
   endtask

   function automatic logic [63:0] outs();
      return {22'd0, pixel, pixel_valid, pixel_index, frame_done, frame_len, err, overflow, busy};
   endfunction

   int pv0, fd0, e0, efd0;
   logic [23:0] p61;

   initial begin
      @(negedge clk);
      cyc(4);
      check("reset_outputs", outs(), 64'd0);
      reset = 1'b1;
      cyc(1100);

      // Single pixel 0xFF0000 at nominal timing
      pv0 = pv_cnt; fd0 = fd_cnt; e0 = err_cnt;
      send_pixel(24'hFF0000);
      check("t1_busy", {63'd0, busy}, 64'd1);
      cyc(1100);
      check("t1_pv_count", pv_cnt - pv0, 1);
      check("t1_pixel", pix_log[pv0], 24'hFF0000);
      check("t1_index", idx_log[pv0], 0);
      check("t1_frame_done", fd_cnt - fd0, 1);
      check("t1_frame_len", last_flen, 1);
      check("t1_err", err_cnt - e0, 0);
      check("t1_busy_low", {63'd0, busy}, 64'd0);

      // Three pixels back to back
      pv0 = pv_cnt;
      send_pixel(24'h123456);
      send_pixel(24'hABCDEF);
      send_pixel(24'h000001);
      cyc(1100);
      check("t2_pv_count", pv_cnt - pv0, 3);
      check("t2_pix0", pix_log[pv0], 24'h123456);
      check("t2_pix1", pix_log[pv0+1], 24'hABCDEF);
      check("t2_pix2", pix_log[pv0+2], 24'h000001);
      check("t2_idx0", idx_log[pv0], 0);
      check("t2_idx1", idx_log[pv0+1], 1);
      check("t2_idx2", idx_log[pv0+2], 2);
      check("t2_frame_len", last_flen, 3);

      // 22 zeros, 11-cycle high (0), 3-cycle glitch (dropped), 12-cycle high (1)
      pv0 = pv_cnt; e0 = err_cnt;
      for (int i = 0; i < 22; i++) send_bit(1'b0);
      pulse(11, 14);
      pulse(3, 22);
      pulse(12, 13);
      cyc(1100);
      check("t3_pv_count", pv_cnt - pv0, 1);
      check("t3_pixel", pix_log[pv0], 24'h000001);
      check("t3_glitch_err", err_cnt - e0, 1);
      check("t3_frame_len", last_flen, 1);

      // 30-cycle high aborts to SYNC without frame_done, then a clean frame
      pv0 = pv_cnt; fd0 = fd_cnt; e0 = err_cnt;
      send_bit(1'b1);
      send_bit(1'b1);
      din = 1'b1;
      cyc(30);
      din = 1'b0;
      cyc(1100);
      check("t4_long_err", err_cnt - e0, 1);
      check("t4_no_frame_done", fd_cnt - fd0, 0);
      check("t4_busy", {63'd0, busy}, 64'd0);
      send_pixel(24'h5A5A5A);
      cyc(1100);
      check("t4_pixel", pix_log[pv0], 24'h5A5A5A);
      check("t4_frame_done", fd_cnt - fd0, 1);

      // Reset mid-frame, release while the line toggles
      pv0 = pv_cnt; fd0 = fd_cnt;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check("t5_busy_mid", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      #1;
      check("t5_reset_outputs", outs(), 64'd0);
      cyc(1);
      send_bit(1'b0);
      din = 1'b1;
      cyc(5);
      reset = 1'b1;
      cyc(11);
      din = 1'b0;
      cyc(9);
      send_pixel(24'hFFFFFF);
      send_pixel(24'h00FF00);
      check("t5_no_pv_toggling", pv_cnt - pv0, 0);
      cyc(1100);
      check("t5_no_pv_after_gap", pv_cnt - pv0, 0);
      check("t5_no_frame_done", fd_cnt - fd0, 0);
      send_pixel(24'hC3A5F0);
      cyc(1100);
      check("t5_pixel", pix_log[pv0], 24'hC3A5F0);
      check("t5_index", idx_log[pv0], 0);
      check("t5_frame_len", last_flen, 1);

      // 61 pixels: 60 strobes, overflow until frame_done
      pv0 = pv_cnt;
      for (int i = 0; i < 61; i++) begin
         p61 = {i[7:0], 16'hA5A5};
         send_pixel(p61);
      end
      check("t6_overflow_set", {63'd0, overflow}, 64'd1);
      cyc(1100);
      check("t6_pv_count", pv_cnt - pv0, 60);
      check("t6_last_pixel", pix_log[pv0+59], {8'd59, 16'hA5A5});
      check("t6_last_index", idx_log[pv0+59], 59);
      check("t6_frame_len", last_flen, 60);
      check("t6_overflow_clear", {63'd0, overflow}, 64'd0);

      // Partial pixel at frame end
      pv0 = pv_cnt; efd0 = err_fd_cnt;
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      cyc(1100);
      check("t7_err_with_frame_done", err_fd_cnt - efd0, 1);
      check("t7_frame_len", last_flen, 0);
      check("t7_no_pv", pv_cnt - pv0, 0);
      e0 = err_cnt;
      send_pixel(24'h0F0F0F);
      cyc(1100);
      check("t7_next_pixel", pix_log[pv0], 24'h0F0F0F);
      check("t7_next_index", idx_log[pv0], 0);
      check("t7_next_err", err_cnt - e0, 0);

      check("err_pv_coincide", coinc_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
